ysyx_25040109_lsu: RTL and testbench
====================================

// Module: ysyx_25040109_lsu
// PURPOSE
//  Load/store stage directly downstream of the execute unit. It takes the EXU result (effective address or ALU
//  value), the store data, and opcode/funct3/rd info over a valid/ready handshake. Loads/stores run as one access
//  on a 32-bit word-aligned memory port; other ops pass through. Results go to writeback over valid/ready.
// PARAMETERS
//  MAX_WAIT   1023  cycles in REQ+WAIT before bus-timeout error; 0 disables timeout
//  CNT_W      10    width of wait counter; must hold MAX_WAIT
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst_n          in   1   asynchronous active-low reset
//  in_valid       in   1   EXU has an instruction
//  in_ready       out  1   LSU accepts it this cycle
//  in_result      in   32  EXU result / effective address
//  in_rs2         in   32  store data
//  in_opcode      in   7   0000011 load, 0100011 store, else pass-through
//  in_funct3      in   3   access size/sign
//  in_rd          in   5   destination register
//  in_wen         in   1   register write enable from EXU
//  mem_req_valid  out  1   memory request
//  mem_req_ready  in   1   memory accepts request
//  mem_addr       out  32  {addr[31:2],2'b00}
//  mem_wr         out  1   1=store, 0=load
//  mem_wdata      out  32  lane-replicated store data
//  mem_wmask      out  4   byte enables (0 for loads)
//  mem_rsp_valid  in   1   read data / write ack
//  mem_rdata      in   32  read word
//  out_valid      out  1   result for writeback
//  out_ready      in   1   writeback accepts
//  out_data       out  32  load value or pass-through result
//  out_rd         out  5   destination register
//  out_wen        out  1   register write enable; 0 on any error
//  out_err        out  2   bit0 bus timeout, bit1 misaligned
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1; mem_req_valid, out_valid, out_wen=0; out_err=0; all data outputs and
//    latched fields=0; counter=0. Reset mid-access drops the op. Memory is reset with the LSU.
//  - FSM IDLE->REQ (mem op accepted) | DONE (non-mem accepted); REQ->WAIT on mem_req_valid&&mem_req_ready;
//    WAIT->DONE on mem_rsp_valid; DONE->IDLE on out_ready, or stay DONE if new op accepted in same cycle.
//  - in_ready = (IDLE) || (DONE && out_ready). Back-to-back pass-through gives 1 op/cycle.
//  - Accept: latch address, store data, opcode, funct3, rd, wen. Outputs are registered. mem_req_valid,
//    addr, wr, wdata and wmask stay stable in REQ until accepted.
//  - Latency (accept at cycle N): pass-through out_valid at N+1. Mem op: req at N+1; with 0-wait memory,
//    rsp at N+2 and out_valid at N+3.
//  - Store: SB mask=0001<<a[1:0], wdata={4{rs2[7:0]}}. SH mask=0011<<{a[1],0}, wdata={2{rs2[15:0]}}.
//    SW mask=1111. Store out_wen=0 and out_data=0.
//  - Load: w=mem_rdata>>(8*a[1:0]). LB sext w[7:0], LBU zext w[7:0], LH sext w[15:0], LHU zext w[15:0],
//    LW w. Undefined funct3 (011/11x) gives out_data=0 and out_wen=0.
//  - Timeout: counter clears on entering REQ and increments each REQ/WAIT cycle. At MAX_WAIT it goes to
//    DONE with out_err[0]=1 and out_wen=0. A mem_rsp_valid outside WAIT is ignored.
//  - out_* are held while out_valid && !out_ready.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with a[0]=1, or LW/SW with a[1:0]!=0, make no memory request.
//    Next cycle DONE with out_err[1]=1, out_wen=0, out_data=0.
//  Not defined: out_err[1] tied 0. Low address bits are truncated to size (LH/SH use a[1] lane, LW/SW the
//    aligned word) and the access proceeds normally.
// TESTING
//  1 Pass-through: in_opcode=0110011, result=0x1234, rd=5, 3 back-to-back ops with out_ready=1
//    -> out_valid on 3 consecutive cycles, out_data=0x1234, out_rd=5.
//  2 LB a=0x80000003, rdata=0x80FF7F01 -> out_data=0xFFFFFF80. LBU -> 0x00000080.
//    LH a=0x80000002 -> 0xFFFF80FF.
//  3 SH a=0x80000002 rs2=0xDEADBEEF -> mem_addr=0x80000000, wmask=1100, wdata=0xBEEFBEEF, out_wen=0.
//  4 mem_req_ready low 4 cycles -> req/addr stable; out_valid 2 cycles after accept+rsp. out_ready low 3
//    cycles -> outputs held and in_ready=0.
//  5 MAX_WAIT=8, memory never responds -> out_valid 9 cycles after accept, out_err=01, out_wen=0.
//    Assert rst_n low mid-WAIT -> all outputs 0 immediately.
//  6 LW a=0x80000001: with LSU_MISALIGN_TRAP_EN -> no mem_req_valid, out_err=10. Without it -> access at
//    0x80000000, out_err=00.

Source files
------------

// File: rtl/ysyx_25040109_lsu.sv
// rtl/ysyx_25040109_lsu.sv - load/store stage with valid/ready in/out and one-beat word memory port
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of truncating the address.
module ysyx_25040109_lsu #(
    parameter int MAX_WAIT = 1023,
    parameter int CNT_W    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic [31:0] in_rs2,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic        in_wen,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic [1:0]  out_err
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [CNT_W-1:0] CNT_LIMIT = (MAX_WAIT == 0) ? '0 : CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
    state_t state, state_nx;

    logic [1:0]       addr_lo_q;
    logic [2:0]       funct3_q;
    logic [4:0]       rd_q;
    logic             wen_q;
    logic             store_q;
    logic [CNT_W-1:0] cnt;

    logic        accept, in_is_store, in_is_mem, in_misalign;
    logic        timeout, finish_rsp, finish_to;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [1:0]  lane;
    logic [31:0] load_word, load_data;
    logic        load_ok;

    assign in_ready      = (state == S_IDLE) || (state == S_DONE && out_ready);
    assign accept        = in_valid && in_ready;
    assign in_is_store   = (in_opcode == OP_STORE);
    assign in_is_mem     = (in_opcode == OP_LOAD) || in_is_store;
    assign mem_req_valid = (state == S_REQ);
    assign out_valid     = (state == S_DONE);

`ifdef LSU_MISALIGN_TRAP_EN
    assign in_misalign = in_is_mem &&
                         ((in_funct3[1:0] == 2'b01 && in_result[0]) ||
                          (in_funct3 == 3'b010 && in_result[1:0] != 2'b00));
`else
    assign in_misalign = 1'b0;
`endif

    // Counter only advances while an access is outstanding, so it always starts from zero in REQ.
    assign timeout    = (MAX_WAIT != 0) && (cnt >= CNT_LIMIT);
    assign finish_rsp = (state == S_WAIT) && mem_rsp_valid;
    assign finish_to  = timeout && ((state == S_REQ && !mem_req_ready) ||
                                    (state == S_WAIT && !mem_rsp_valid));

    always_comb begin
        st_mask = 4'b0000;
        st_data = in_rs2;
        case (in_funct3)
            3'b000: begin
                st_mask = 4'b0001 << in_result[1:0];
                st_data = {4{in_rs2[7:0]}};
            end
            3'b001: begin
                st_mask = 4'b0011 << {in_result[1], 1'b0};
                st_data = {2{in_rs2[15:0]}};
            end
            3'b010:  st_mask = 4'b1111;
            default: st_mask = 4'b0000;
        endcase
    end

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   lane = addr_lo_q;
            2'b01:   lane = {addr_lo_q[1], 1'b0};
            default: lane = 2'b00;
        endcase
        load_word = mem_rdata >> {lane, 3'b000};
        load_ok   = 1'b1;
        case (funct3_q)
            3'b000:  load_data = {{24{load_word[7]}}, load_word[7:0]};
            3'b100:  load_data = {24'h0, load_word[7:0]};
            3'b001:  load_data = {{16{load_word[15]}}, load_word[15:0]};
            3'b101:  load_data = {16'h0, load_word[15:0]};
            3'b010:  load_data = load_word;
            default: begin
                load_data = 32'h0;
                load_ok   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (state == S_DONE && out_ready) state_nx = S_IDLE;
                if (accept) state_nx = (in_is_mem && !in_misalign) ? S_REQ : S_DONE;
            end
            S_REQ: begin
                if (mem_req_ready)  state_nx = S_WAIT;
                else if (finish_to) state_nx = S_DONE;
            end
            S_WAIT: begin
                if (finish_rsp || finish_to) state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_lo_q <= 2'b00;
            funct3_q  <= 3'b000;
            rd_q      <= 5'd0;
            wen_q     <= 1'b0;
            store_q   <= 1'b0;
            cnt       <= '0;
            mem_addr  <= 32'h0;
            mem_wr    <= 1'b0;
            mem_wdata <= 32'h0;
            mem_wmask <= 4'b0000;
            out_data  <= 32'h0;
            out_rd    <= 5'd0;
            out_wen   <= 1'b0;
            out_err   <= 2'b00;
        end else begin
            if (state == S_REQ || state == S_WAIT) cnt <= cnt + 1'b1;
            if (accept) begin
                addr_lo_q <= in_result[1:0];
                funct3_q  <= in_funct3;
                rd_q      <= in_rd;
                wen_q     <= in_wen;
                store_q   <= in_is_store;
                if (in_is_mem) begin
                    cnt       <= '0;
                    mem_addr  <= {in_result[31:2], 2'b00};
                    mem_wr    <= in_is_store;
                    mem_wdata <= in_is_store ? st_data : 32'h0;
                    mem_wmask <= in_is_store ? st_mask : 4'b0000;
                end
                if (!in_is_mem) begin
                    out_data <= in_result;
                    out_rd   <= in_rd;
                    out_wen  <= in_wen;
                    out_err  <= 2'b00;
                end else if (in_misalign) begin
                    out_data <= 32'h0;
                    out_rd   <= in_rd;
                    out_wen  <= 1'b0;
                    out_err  <= 2'b10;
                end
            end
            if (finish_rsp) begin
                out_data <= store_q ? 32'h0 : load_data;
                out_rd   <= rd_q;
                out_wen  <= !store_q && wen_q && load_ok;
                out_err  <= 2'b00;
            end else if (finish_to) begin
                out_data <= 32'h0;
                out_rd   <= rd_q;
                out_wen  <= 1'b0;
                out_err  <= 2'b01;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
// tb/tb_ysyx_25040109_lsu.sv - scoreboard bench for ysyx_25040109_lsu with a 0-wait memory model
module tb_ysyx_25040109_lsu;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_result, in_rs2;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        mem_req_valid, mem_req_ready, mem_wr, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        out_valid, out_ready, out_wen;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic [1:0]  out_err;

    ysyx_25040109_lsu #(.MAX_WAIT(8), .CNT_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_rs2(in_rs2),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rd(in_rd), .in_wen(in_wen),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_wen(out_wen), .out_err(out_err)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic [1:0]  err;
        int          lat;
        int          acc;
        int          tag;
    } out_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_exp_t;

    out_exp_t out_q[$];
    mem_exp_t mem_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  req_cycles = 0;
    bit  mem_mute = 0;

    bit          hs, pend;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_mask;
    logic        p_wr;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Memory: accepts whenever mem_req_ready, answers the cycle after the handshake unless muted.
    initial begin
        mem_rsp_valid = 0;
        pend = 0;
        forever begin
            @(negedge clk);
            hs = rst_n && mem_req_valid && mem_req_ready;
            if (mem_req_valid) req_cycles++;
            if (pend) begin
                check_eq("req_hold_valid", {31'h0, mem_req_valid}, 32'h1);
                check_eq("req_hold_addr", mem_addr, p_addr);
                check_eq("req_hold_wdata", mem_wdata, p_wdata);
                check_eq("req_hold_ctl", {27'h0, mem_wr, mem_wmask}, {27'h0, p_wr, p_mask});
            end
            pend    = rst_n && mem_req_valid && !mem_req_ready;
            p_addr  = mem_addr;
            p_wdata = mem_wdata;
            p_mask  = mem_wmask;
            p_wr    = mem_wr;
            if (hs) begin
                if (mem_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: addr 0x%08h", mem_addr);
                end else begin
                    mem_exp_t m;
                    m = mem_q.pop_front();
                    check_eq("req_addr", mem_addr, m.addr);
                    check_eq("req_wdata", mem_wdata, m.wdata);
                    check_eq("req_ctl", {27'h0, mem_wr, mem_wmask}, {27'h0, m.wr, m.wmask});
                end
            end
            @(posedge clk);
            #1;
            mem_rsp_valid = hs && !mem_mute;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            if (out_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: data 0x%08h", out_data);
            end else begin
                out_exp_t e;
                e = out_q.pop_front();
                check_eq($sformatf("out_data_%0d", e.tag), out_data, e.data);
                check_eq($sformatf("out_ctl_%0d", e.tag), {24'h0, out_rd, out_wen, out_err},
                         {24'h0, e.rd, e.wen, e.err});
                if (e.lat >= 0) check_eq($sformatf("latency_%0d", e.tag), cyc - e.acc, e.lat);
            end
        end
    end

    task automatic exp_mem(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input logic [3:0] wmask);
        mem_exp_t m;
        m.addr = addr; m.wr = wr; m.wdata = wdata; m.wmask = wmask;
        mem_q.push_back(m);
    endtask

    task automatic issue(input logic [31:0] res, input logic [31:0] rs2, input logic [6:0] op,
                         input logic [2:0] f3, input logic [4:0] rd, input logic wen,
                         input bit exp_out, input logic [31:0] e_data, input logic e_wen,
                         input logic [1:0] e_err, input int e_lat, input int tag, output int acc);
        int n;
        out_exp_t e;
        n = 0;
        in_valid = 1; in_result = res; in_rs2 = rs2; in_opcode = op;
        in_funct3 = f3; in_rd = rd; in_wen = wen;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        acc = cyc;
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_%0d: in_ready stayed 0", tag);
        end else if (exp_out) begin
            e.data = e_data; e.rd = rd; e.wen = e_wen; e.err = e_err;
            e.lat = e_lat; e.acc = acc; e.tag = tag;
            out_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((out_q.size() != 0 || mem_q.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (out_q.size() != 0 || mem_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d outputs and %0d requests still expected", out_q.size(), mem_q.size());
            out_q.delete();
            mem_q.delete();
        end
    endtask

    int acc0, acc1, acc2, r0;
    // Each row: address, funct3, expected load value, expected out_wen.
    logic [31:0] ld_addr [7] = '{32'h80000003, 32'h80000003, 32'h80000002, 32'h80000002,
                                 32'h80000000, 32'h80000001, 32'h80000000};
    logic [2:0]  ld_f3   [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b011};
    logic [31:0] ld_exp  [7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF,
                                 32'h80FF7F01, 32'h0000007F, 32'h00000000};
    logic        ld_wen  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst_n = 0; in_valid = 0; in_result = 0; in_rs2 = 0; in_opcode = 0; in_funct3 = 0;
        in_rd = 0; in_wen = 0; mem_req_ready = 1; mem_rdata = 32'h80FF7F01; out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_in_ready", {31'h0, in_ready}, 32'h1);
        check_eq("reset_valids", {29'h0, out_valid, mem_req_valid, out_wen}, 32'h0);
        check_eq("reset_out", {25'h0, out_rd, out_err}, 32'h0);
        check_eq("reset_out_data", out_data, 32'h0);
        rst_n = 1;
        @(posedge clk);
        #1;

        issue(32'h1234, 0, OP_ALU, 3'b000, 5'd5, 1'b1, 1, 32'h1234, 1'b1, 2'b00, 1, 1, acc0);
        issue(32'h1234, 0, OP_ALU, 3'b000, 5'd5, 1'b1, 1, 32'h1234, 1'b1, 2'b00, 1, 2, acc1);
        issue(32'h1234, 0, OP_ALU, 3'b000, 5'd5, 1'b1, 1, 32'h1234, 1'b1, 2'b00, 1, 3, acc2);
        check_eq("pass_back_to_back", acc2 - acc0, 2);
        drain();

        for (int i = 0; i < 7; i++) begin
            exp_mem({ld_addr[i][31:2], 2'b00}, 1'b0, 32'h0, 4'b0000);
            issue(ld_addr[i], 32'hFFFFFFFF, OP_LOAD, ld_f3[i], 5'd7, 1'b1, 1, ld_exp[i], ld_wen[i],
                  2'b00, 3, 10 + i, acc0);
            drain();
        end

        exp_mem(32'h80000000, 1'b1, 32'hBEEFBEEF, 4'b1100);
        issue(32'h80000002, 32'hDEADBEEF, OP_STORE, 3'b001, 5'd3, 1'b1, 1, 32'h0, 1'b0, 2'b00, 3, 20, acc0);
        exp_mem(32'h80000100, 1'b1, 32'hA5A5A5A5, 4'b0010);
        issue(32'h80000101, 32'h000000A5, OP_STORE, 3'b000, 5'd3, 1'b1, 1, 32'h0, 1'b0, 2'b00, 3, 21, acc0);
        exp_mem(32'h80000204, 1'b1, 32'h01234567, 4'b1111);
        issue(32'h80000204, 32'h01234567, OP_STORE, 3'b010, 5'd3, 1'b1, 1, 32'h0, 1'b0, 2'b00, 3, 22, acc0);
        drain();

        mem_req_ready = 0;
        exp_mem(32'h80000040, 1'b0, 32'h0, 4'b0000);
        issue(32'h80000040, 0, OP_LOAD, 3'b010, 5'd9, 1'b1, 1, 32'h80FF7F01, 1'b1, 2'b00, 7, 30, acc0);
        repeat (4) @(posedge clk);
        #1;
        mem_req_ready = 1;
        drain();

        out_ready = 0;
        issue(32'h5555AAAA, 0, OP_ALU, 3'b000, 5'd12, 1'b1, 1, 32'h5555AAAA, 1'b1, 2'b00, -1, 31, acc0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("hold_out_data", out_data, 32'h5555AAAA);
            check_eq("hold_flags", {29'h0, out_valid, in_ready, out_wen}, 32'h5);
            check_eq("hold_rd", {27'h0, out_rd}, 32'd12);
        end
        @(posedge clk);
        #1;
        out_ready = 1;
        drain();

        mem_mute = 1;
        exp_mem(32'h80000080, 1'b0, 32'h0, 4'b0000);
        issue(32'h80000080, 0, OP_LOAD, 3'b010, 5'd4, 1'b1, 1, 32'h0, 1'b0, 2'b01, 9, 40, acc0);
        drain();
        exp_mem(32'h80000090, 1'b0, 32'h0, 4'b0000);
        issue(32'h80000090, 0, OP_LOAD, 3'b010, 5'd4, 1'b1, 0, 32'h0, 1'b0, 2'b00, -1, 41, acc0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        check_eq("rst_mid_flags", {28'h0, out_valid, mem_req_valid, out_wen, mem_wr}, 32'h0);
        check_eq("rst_mid_out", {21'h0, out_rd, out_err, mem_wmask}, 32'h0);
        check_eq("rst_mid_data", out_data | mem_addr | mem_wdata, 32'h0);
        check_eq("rst_mid_in_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1;
        mem_mute = 0;
        @(posedge clk);
        #1;

`ifdef LSU_MISALIGN_TRAP_EN
        r0 = req_cycles;
        issue(32'h80000001, 0, OP_LOAD, 3'b010, 5'd6, 1'b1, 1, 32'h0, 1'b0, 2'b10, 1, 50, acc0);
        issue(32'h80000003, 32'h1111, OP_STORE, 3'b001, 5'd6, 1'b1, 1, 32'h0, 1'b0, 2'b10, 1, 51, acc0);
        drain();
        check_eq("misalign_no_req", req_cycles - r0, 0);
`else
        exp_mem(32'h80000000, 1'b0, 32'h0, 4'b0000);
        issue(32'h80000001, 0, OP_LOAD, 3'b010, 5'd6, 1'b1, 1, 32'h80FF7F01, 1'b1, 2'b00, 3, 50, acc0);
        drain();
`endif

        repeat (3) @(posedge clk);
        #1;
        check_eq("final_idle", {30'h0, out_valid, in_ready}, 32'h1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
